// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - sequential WIDTH x WIDTH multiplier built around one shared 4x4 multiplier
// Walks nibble pairs (i fastest), shift-accumulating each 4x4 partial product into acc.
module mul_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic [3:0]         mul_a,
  output logic [3:0]         mul_b,
  input  logic [7:0]         mul_out
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 2) ? 2 : 1;
  localparam int PW  = 2 * WIDTH;
  localparam logic [IW-1:0] IMAX = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [PW-1:0]   acc_q, product_q, term, sum;
  logic [IW-1:0]   i_q, j_q;
  logic [IW:0]     ij;
  logic            last;

  assign last    = (i_q == IMAX) && (j_q == IMAX);
  assign ij      = {1'b0, i_q} + {1'b0, j_q};
  // Partial product weight is 16^(i+j); the 2*WIDTH accumulator cannot overflow.
  assign term    = PW'(mul_out) << {ij, 2'b00};
  assign sum     = acc_q + term;
  assign product = product_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = CALC;
      CALC:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    mul_a     = 4'h0;
    mul_b     = 4'h0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      CALC: begin
        busy  = 1'b1;
        mul_a = a_q[{i_q, 2'b00} +: 4];
        mul_b = b_q[{j_q, 2'b00} +: 4];
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      i_q       <= '0;
      j_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q   <= in_a;
          b_q   <= in_b;
          acc_q <= '0;
          i_q   <= '0;
          j_q   <= '0;
        end
        CALC: begin
          acc_q <= sum;
          if (last) product_q <= sum;
          if (i_q == IMAX) begin
            i_q <= '0;
            j_q <= j_q + 1'b1;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - self-checking bench for mul_seq_ctrl (WIDTH=8 and WIDTH=16 instances)
module tb_mul_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel16 = 1'b0;
  logic        iv = 1'b0;
  logic        ordy = 1'b1;
  logic [15:0] a_drv = '0;
  logic [15:0] b_drv = '0;
  int errors = 0;
  int checks = 0;

  logic        iv8, ir8, ov8, busy8;
  logic [15:0] p8;
  logic [3:0]  ma8, mb8;
  logic [7:0]  mo8;
  logic        iv16, ir16, ov16, busy16;
  logic [31:0] p16;
  logic [3:0]  ma16, mb16;
  logic [7:0]  mo16;

  assign iv8  = iv & ~sel16;
  assign iv16 = iv & sel16;
  assign mo8  = {4'h0, ma8} * {4'h0, mb8};
  assign mo16 = {4'h0, ma16} * {4'h0, mb16};

  mul_seq_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .in_a(a_drv[7:0]), .in_b(b_drv[7:0]), .out_valid(ov8), .out_ready(ordy),
    .product(p8), .busy(busy8), .mul_a(ma8), .mul_b(mb8), .mul_out(mo8)
  );

  mul_seq_ctrl #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .in_a(a_drv), .in_b(b_drv), .out_valid(ov16), .out_ready(ordy),
    .product(p16), .busy(busy16), .mul_a(ma16), .mul_b(mb16), .mul_out(mo16)
  );

  logic        in_rdy, ov, busy;
  logic [31:0] prod;
  logic [3:0]  ma, mb;
  assign in_rdy = sel16 ? ir16 : ir8;
  assign ov     = sel16 ? ov16 : ov8;
  assign busy   = sel16 ? busy16 : busy8;
  assign prod   = sel16 ? p16 : {16'h0, p8};
  assign ma     = sel16 ? ma16 : ma8;
  assign mb     = sel16 ? mb16 : mb8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] nib(input logic [15:0] v, input int k);
    return 32'((v >> (4 * k)) & 16'hF);
  endfunction

  // Called at a negedge with the selected instance idle; returns at a negedge after the handshake.
  task automatic op(input logic w16, input logic [15:0] a, input logic [15:0] b,
                    input int hold, input logic keep_valid);
    int nn, passes, lat;
    logic [31:0] exp;
    nn     = w16 ? 4 : 2;
    passes = nn * nn;
    exp    = w16 ? 32'(a) * 32'(b) : 32'(a[7:0]) * 32'(b[7:0]);
    sel16 = w16; a_drv = a; b_drv = b; iv = 1'b1; ordy = (hold == 0);
    check("accept_ready", {31'h0, in_rdy}, 32'h1);
    @(posedge clk); #1;
    iv = keep_valid;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (ov || lat > passes + 4) break;
      check("calc_flags", {in_rdy, busy}, 2'b01);
      check("mul_a", {28'h0, ma}, nib(a, (lat - 1) % nn));
      check("mul_b", {28'h0, mb}, nib(b, (lat - 1) / nn));
    end
    check("latency", lat, passes + 1);
    check("product", prod, exp);
    check("done_flags", {in_rdy, busy, ma, mb}, {1'b0, 1'b1, 8'h00});
    for (int k = 0; k < hold; k++) begin
      iv = 1'b1; a_drv = ~a; b_drv = ~b;
      @(negedge clk);
      check("hold_flags", {ov, in_rdy}, 2'b10);
      check("hold_product", prod, exp);
    end
    if (hold > 0) begin
      iv = 1'b0; ordy = 1'b1;
    end
    @(negedge clk);
    check("valid_drop", {31'h0, ov}, 32'h0);
    check("product_kept", prod, exp);
    check("ready_back", {31'h0, in_rdy}, 32'h1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_flags", {ir8, ov8, busy8, ir16, ov16, busy16}, 6'b100100);
    check("rst_prod8", {16'h0, p8}, 32'h0);
    check("rst_prod16", p16, 32'h0);
    check("rst_mul", {ma8, mb8, ma16, mb16}, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    op(1'b0, 16'h00FF, 16'h00FF, 0, 1'b0);
    op(1'b0, 16'h0000, 16'h00A5, 0, 1'b0);
    op(1'b0, 16'h0012, 16'h0034, 3, 1'b0);
    op(1'b0, 16'h000F, 16'h0010, 0, 1'b1);
    op(1'b0, 16'h0080, 16'h0002, 0, 1'b0);

    sel16 = 1'b0; a_drv = 16'h0077; b_drv = 16'h0099; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags", {ir8, ov8, busy8}, 3'b100);
    check("mid_rst_prod", {16'h0, p8}, 32'h0);
    check("mid_rst_mul", {ma8, mb8}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op(1'b0, 16'h0003, 16'h0005, 0, 1'b0);

    op(1'b1, 16'hFFFF, 16'hFFFF, 0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      op(1'($urandom % 2), 16'($urandom), 16'($urandom), int'($urandom % 3), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
